// File: rtl/msg_io_bridge.sv
// Byte-serial software handshake to a wide message core: loads BIN bytes into in_data, waits for out_valid, then unloads BOUT bytes.
// Registered status one cycle after each command; software paces every byte, to_hw_sig=11 or a PROC timeout aborts.
module msg_io_bridge #(
    parameter int PORT_W  = 8,
    parameter int MSG_W   = 128,
    parameter int N_IN    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            to_hw_sig,
    input  logic [PORT_W-1:0]     to_hw_port,
    output logic [1:0]            to_sw_sig,
    output logic [PORT_W-1:0]     to_sw_port,
    output logic [N_IN*MSG_W-1:0] in_data,
    output logic                  in_valid,
    input  logic [MSG_W-1:0]      out_data,
    input  logic                  out_valid,
    output logic                  busy
);

    localparam int DW   = N_IN * MSG_W;
    localparam int BIN  = DW / PORT_W;
    localparam int BOUT = MSG_W / PORT_W;
    localparam int LCW  = $clog2(BIN + 1);
    localparam int UCW  = $clog2(BOUT + 1);
    localparam int PCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LCW-1:0] BIN_V  = LCW'(BIN);
    localparam logic [UCW-1:0] BOUT_V = UCW'(BOUT);
    localparam logic [PCW-1:0] TO_V   = PCW'(TIMEOUT);

    if ((MSG_W % PORT_W) != 0 || N_IN < 1 || N_IN > 4) begin : g_param_check
        $error("msg_io_bridge: MSG_W must be a multiple of PORT_W and N_IN must be 1..4");
    end

    typedef enum logic [2:0] {
        LOAD, LOAD_ACK, PROC, UNLOAD, UNLOAD_ACK, ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sig_q, sig_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [DW-1:0]     in_data_q, in_data_d;
    logic [MSG_W-1:0]  out_sr_q, out_sr_d;
    logic [LCW-1:0]    load_cnt_q, load_cnt_d;
    logic [UCW-1:0]    unload_cnt_q, unload_cnt_d;
    logic [PCW-1:0]    proc_cnt_q, proc_cnt_d;
    logic              in_valid_c;

    always_comb begin
        state_d      = state_q;
        sig_d        = sig_q;
        port_d       = port_q;
        in_data_d    = in_data_q;
        out_sr_d     = out_sr_q;
        load_cnt_d   = load_cnt_q;
        unload_cnt_d = unload_cnt_q;
        proc_cnt_d   = proc_cnt_q;
        in_valid_c   = 1'b0;

        // Abort outranks everything, including a result arriving in the same cycle.
        if (state_q != ABORT && to_hw_sig == 2'b11) begin
            state_d      = ABORT;
            sig_d        = 2'b11;
            load_cnt_d   = '0;
            unload_cnt_d = '0;
            proc_cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (to_hw_sig == 2'b01) begin
                        in_data_d  = (in_data_q << PORT_W) | DW'(to_hw_port);
                        load_cnt_d = load_cnt_q + 1'b1;
                        state_d    = LOAD_ACK;
                        sig_d      = 2'b01;
                    end
                end
                LOAD_ACK: begin
                    if (to_hw_sig == 2'b00) begin
                        sig_d = 2'b00;
                        if (load_cnt_q == BIN_V) begin
                            in_valid_c = 1'b1;
                            load_cnt_d = '0;
                            proc_cnt_d = '0;
                            state_d    = PROC;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                PROC: begin
                    proc_cnt_d = proc_cnt_q + 1'b1;
                    if (out_valid) begin
                        out_sr_d = out_data;
                        state_d  = UNLOAD;
                        sig_d    = 2'b10;
                    end else if (TIMEOUT > 0 && proc_cnt_d == TO_V) begin
                        state_d    = ABORT;
                        sig_d      = 2'b11;
                        proc_cnt_d = '0;
                    end
                end
                UNLOAD: begin
                    if (to_hw_sig == 2'b10) begin
                        port_d  = out_sr_q[MSG_W-1 -: PORT_W];
                        sig_d   = 2'b01;
                        state_d = UNLOAD_ACK;
                    end
                end
                UNLOAD_ACK: begin
                    if (to_hw_sig == 2'b00) begin
                        out_sr_d     = out_sr_q << PORT_W;
                        unload_cnt_d = unload_cnt_q + 1'b1;
                        if (unload_cnt_d == BOUT_V) begin
                            state_d      = LOAD;
                            sig_d        = 2'b00;
                            unload_cnt_d = '0;
                            load_cnt_d   = '0;
                            proc_cnt_d   = '0;
                        end else begin
                            state_d = UNLOAD;
                            sig_d   = 2'b10;
                        end
                    end
                end
                ABORT: begin
                    load_cnt_d   = '0;
                    unload_cnt_d = '0;
                    proc_cnt_d   = '0;
                    if (to_hw_sig == 2'b00) begin
                        state_d = LOAD;
                        sig_d   = 2'b00;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            sig_q        <= 2'b00;
            port_q       <= '0;
            in_data_q    <= '0;
            out_sr_q     <= '0;
            load_cnt_q   <= '0;
            unload_cnt_q <= '0;
            proc_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sig_q        <= sig_d;
            port_q       <= port_d;
            in_data_q    <= in_data_d;
            out_sr_q     <= out_sr_d;
            load_cnt_q   <= load_cnt_d;
            unload_cnt_q <= unload_cnt_d;
            proc_cnt_q   <= proc_cnt_d;
        end
    end

    // in_valid fires in the release cycle so the core may answer from the very first PROC cycle.
    assign in_valid   = in_valid_c & ~reset;
    assign to_sw_sig  = sig_q;
    assign to_sw_port = port_q;
    assign in_data    = in_data_q;
    assign busy       = !(state_q == LOAD && load_cnt_q == '0);

endmodule

// File: tb/tb_msg_io_bridge.sv
// Directed bench for msg_io_bridge: per-cycle comparison against an expectation model driven by the handshake tasks.
module tb_msg_io_bridge;

    localparam int PORT_W  = 8;
    localparam int MSG_W   = 128;
    localparam int N_IN    = 2;
    localparam int TIMEOUT = 16;
    localparam int BIN     = N_IN * MSG_W / PORT_W;
    localparam int BOUT    = MSG_W / PORT_W;
    localparam logic [127:0] RES_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] RES_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] RES_C = 128'hDEADBEEF00112233445566778899AABB;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [1:0]   to_hw_sig  = 2'b00;
    logic [7:0]   to_hw_port = 8'h00;
    logic [1:0]   to_sw_sig;
    logic [7:0]   to_sw_port;
    logic [255:0] in_data;
    logic         in_valid;
    logic [127:0] out_data   = '0;
    logic         out_valid  = 1'b0;
    logic         busy;

    msg_io_bridge #(
        .PORT_W (PORT_W),
        .MSG_W  (MSG_W),
        .N_IN   (N_IN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .to_hw_sig (to_hw_sig),
        .to_hw_port(to_hw_port),
        .to_sw_sig (to_sw_sig),
        .to_sw_port(to_sw_port),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // Expectation model: what software must observe in the current cycle.
    logic [1:0]   exp_sig  = 2'b00;
    logic [7:0]   exp_port = 8'h00;
    logic [255:0] exp_in   = '0;
    logic         exp_iv   = 1'b0;
    logic         exp_busy = 1'b0;
    int           m_loaded = 0;
    logic [127:0] m_result = '0;
    logic         ov_bg    = 1'b0;
    logic [7:0]   got [BOUT];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("to_sw_sig", 256'(to_sw_sig), 256'(exp_sig));
            check("to_sw_port", 256'(to_sw_port), 256'(exp_port));
            check("in_data", in_data, exp_in);
            check("in_valid", 256'(in_valid), 256'(exp_iv));
            check("busy", 256'(busy), 256'(exp_busy));
        end
    end

    // One cycle: apply inputs just after the edge and state what this cycle must show.
    task automatic drive(input logic [1:0] sig, input logic [7:0] port, input logic ov,
                         input logic [1:0] e_sig, input logic e_busy, input logic e_iv);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        to_hw_sig  = sig;
        to_hw_port = port;
        out_valid  = ov | ov_bg;
        exp_sig    = e_sig;
        exp_busy   = e_busy;
        exp_iv     = e_iv;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(2'b01, b, 1'b0, 2'b00, m_loaded != 0, 1'b0);
        m_loaded++;
        drive(2'b00, 8'h00, 1'b0, 2'b01, 1'b1, m_loaded == BIN);
        exp_in = {exp_in[247:0], b};
        if (m_loaded == BIN) m_loaded = 0;
    endtask

    task automatic load_all(input logic [7:0] base);
        for (int i = 0; i < BIN; i++) send_byte(base + 8'(i));
    endtask

    task automatic proc_wait(input int n, input logic [127:0] val);
        for (int i = 0; i < n; i++) drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        out_data = val;
        drive(2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0);
        m_result = val;
    endtask

    task automatic unload_byte(input int k);
        drive(2'b10, 8'h00, 1'b0, 2'b10, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0);
        exp_port = 8'(m_result >> (8 * (BOUT - 1 - k)));
    endtask

    task automatic unload_all();
        for (int k = 0; k < BOUT; k++) begin
            unload_byte(k);
            @(negedge clk);
            got[k] = to_sw_port;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;

        // Idle LOAD ignores a byte request.
        drive(2'b10, 8'h55, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Full load 0x00..0x1F, result RES_A, full unload.
        load_all(8'h00);
        @(negedge clk);
        check("lit_in_msb", 256'(in_data[255:248]), 256'(8'h00));
        check("lit_in_lsb", 256'(in_data[7:0]), 256'(8'h1F));
        check("lit_in_valid", 256'(in_valid), 256'(1'b1));
        proc_wait(3, RES_A);
        drive(2'b01, 8'hAA, 1'b0, 2'b10, 1'b1, 1'b0);
        unload_all();
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        check("lit_byte0", 256'(got[0]), 256'(8'h01));
        check("lit_byte1", 256'(got[1]), 256'(8'h23));
        check("lit_byte7", 256'(got[7]), 256'(8'hEF));
        check("lit_byte15", 256'(got[15]), 256'(8'hEF));

        // Timeout: 16 PROC cycles without a result, then abort status.
        load_all(8'h40);
        for (int i = 0; i < TIMEOUT; i++) drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b11, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("lit_timeout_busy", 256'(busy), 256'(1'b0));

        // Result on the last PROC cycle before timeout is still accepted.
        load_all(8'h80);
        proc_wait(TIMEOUT - 1, RES_B);
        unload_all();
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Abort after 5 bytes, then a fresh load counts from zero.
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
        drive(2'b11, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        drive(2'b11, 8'h00, 1'b0, 2'b11, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b11, 1'b1, 1'b0);
        m_loaded = 0;
        load_all(8'h20);
        proc_wait(0, RES_C);
        unload_all();
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Abort beats a simultaneous out_valid in PROC.
        load_all(8'h60);
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        drive(2'b11, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b11, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // out_valid held through loading is only taken on the first PROC cycle.
        ov_bg    = 1'b1;
        out_data = RES_B;
        load_all(8'h10);
        drive(2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0);
        ov_bg    = 1'b0;
        m_result = RES_B;
        unload_all();
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Reset while in UNLOAD_ACK, then a clean transaction.
        load_all(8'hA0);
        proc_wait(2, RES_C);
        unload_byte(0);
        unload_byte(1);
        drive(2'b10, 8'h00, 1'b0, 2'b10, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0);
        exp_port = 8'(RES_C >> (8 * (BOUT - 3)));
        reset    = 1'b1;
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        exp_port = 8'h00;
        exp_in   = '0;
        m_loaded = 0;
        @(negedge clk);
        check("lit_rst_in_data", in_data, 256'd0);
        check("lit_rst_sig", 256'(to_sw_sig), 256'(2'b00));
        load_all(8'h33);
        proc_wait(1, RES_A);
        unload_all();
        drive(2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        check("lit_final_byte0", 256'(got[0]), 256'(8'h01));

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/msg_io_bridge.md
MSG_IO_BRIDGE -- requirements
Module: msg_io_bridge

Interface
REQ-001 Parameter PORT_W, default 8: width in bits of each handshake data port.
REQ-002 Parameter MSG_W, default 128: width in bits of one message word, such as a message, a key or a result.
REQ-003 Parameter N_IN, default 2, legal range 1..4: number of MSG_W words loaded per transaction.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles to wait for out_valid; 0 disables the timeout.
REQ-005 Elaboration SHALL fail if MSG_W is not a multiple of PORT_W or N_IN is outside 1..4.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 to_hw_sig  in  2  software command: 00 idle, 01 byte present, 10 byte request, 11 abort.
REQ-009 to_hw_port  in  PORT_W  byte from software.
REQ-010 to_sw_sig  out  2  hardware status: 00 idle, 01 ack, 10 result ready, 11 error/abort.
REQ-011 to_sw_port  out  PORT_W  result byte to software.
REQ-012 in_data  out  N_IN*MSG_W  assembled input; word 0 occupies the MSBs.
REQ-013 in_valid  out  1  one-cycle pulse: in_data is complete.
REQ-014 out_data  in  MSG_W  result from the processing core.
REQ-015 out_valid  in  1  out_data is valid; sampled only in PROC.
REQ-016 busy  out  1  high in every state except LOAD with a byte count of 0.

Function
REQ-017 The block SHALL define BIN = N_IN*MSG_W/PORT_W and BOUT = MSG_W/PORT_W; counters SHALL be sized to hold these values.
REQ-018 The FSM SHALL have exactly the states LOAD, LOAD_ACK, PROC, UNLOAD, UNLOAD_ACK and ABORT.
REQ-019 LOAD, on to_hw_sig=01: shift to_hw_port into in_data from the LSB side (shift-left), so the first byte ends in the MSBs; increment the load count; go to LOAD_ACK; drive to_sw_sig=01 from the next cycle.
REQ-020 LOAD_ACK: hold to_sw_sig=01 until to_hw_sig=00.
REQ-021 LOAD_ACK release, count<BIN: go to LOAD with to_sw_sig=00.
REQ-022 LOAD_ACK release, count=BIN: pulse in_valid for exactly one cycle, clear the count, go to PROC with to_sw_sig=00.
REQ-023 in_data SHALL be held stable from the in_valid pulse until the first byte of the next transaction is accepted.
REQ-024 PROC: a cycle counter SHALL increment each cycle; on out_valid=1, latch out_data into an output shift register, go to UNLOAD, and drive to_sw_sig=10.
REQ-025 PROC timeout: if TIMEOUT>0 and the counter reaches TIMEOUT without out_valid, go to ABORT.
REQ-026 out_valid outside PROC SHALL be ignored, including in the in_valid cycle.
REQ-027 UNLOAD, on to_hw_sig=10: drive to_sw_port with the current MSB byte of the output register and to_sw_sig=01, then go to UNLOAD_ACK.
REQ-028 UNLOAD_ACK, on to_hw_sig=00: shift the output register left by PORT_W and increment the unload count.
REQ-029 After that shift, if unload count<BOUT: go to UNLOAD with to_sw_sig=10.
REQ-030 After that shift, if unload count=BOUT: go to LOAD with to_sw_sig=00 and both counts cleared.
REQ-031 to_sw_port SHALL hold the last driven byte until the next byte is driven.
REQ-032 Abort: to_hw_sig=11 in any state except ABORT SHALL force ABORT on the next cycle; abort SHALL win over a simultaneous out_valid.
REQ-033 ABORT: drive to_sw_sig=11, clear all counters, and suppress in_valid.
REQ-034 ABORT exit: on to_hw_sig=00, go to LOAD with to_sw_sig=00.
REQ-035 to_hw_sig=10 in LOAD and to_hw_sig=01 in UNLOAD SHALL be ignored with no state change.

Reset
REQ-036 reset=1 SHALL force LOAD, clear all counters, the output register and in_data, and drive to_sw_sig=00, to_sw_port=0, in_valid=0 and busy=0 on the next edge.
REQ-037 reset mid-transaction SHALL discard all partial data; reset SHALL take priority over every other input.

Verification
REQ-038 Load 32 bytes 0x00..0x1F with full handshakes -> one in_valid pulse; in_data[255:248]=0x00 and in_data[7:0]=0x1F.
REQ-039 out_valid with out_data=0x0123..EF repeated, then 16 unload requests -> bytes 0x01,0x23,...,0xEF in order; to_sw_sig=10 between bytes and 00 after the last.
REQ-040 TIMEOUT=16 with no out_valid -> to_sw_sig=11 at cycle 16 of PROC; after to_hw_sig=00, LOAD with busy=0.
REQ-041 Abort after byte 5 -> to_sw_sig=11 and no in_valid; a new 32-byte load is then accepted from count 0.
REQ-042 reset pulsed during UNLOAD_ACK -> all outputs 0 next cycle; the subsequent transaction is correct.
REQ-043 out_valid held high throughout loading -> no transition until PROC; the result is latched on the first PROC cycle.
